// File: rtl/corevx_bus_pkg.sv
// corevx_bus_pkg: memory bus response codes and responder FSM state type
package corevx_bus_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, STALL, ACCEPT, RDWAIT, RESP} resp_state_e;
endpackage

// File: rtl/corevx_mem_responder_array.sv
// corevx_mem_responder_array: byte-enabled single-port RAM with registered read, no reset
module corevx_mem_responder_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (we_i)
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    if (re_i) rdata_o <= mem_q[idx_i];
  end
endmodule

// File: rtl/corevx_mem_responder.sv
// corevx_mem_responder: memory bus target with programmable wait states,
// fixed read latency and SLVERR on out-of-range, misaligned or read+write requests
module corevx_mem_responder
  import corevx_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    WAIT_CYCLES  = 1,
  parameter int                    READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_address_i,
  input  logic                  s_read_i,
  input  logic                  s_write_i,
  input  logic [31:0]           s_writedata_i,
  input  logic [3:0]            s_byteenable_i,
  output logic                  s_waitrequest_o,
  output logic [31:0]           s_readdata_o,
  output logic                  s_readdatavalid_o,
  output logic [1:0]            s_response_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
  resp_state_e state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q, ram_rdata;
  logic [1:0]  resp_q;
  logic        err_q, req, err, wr_only, acc, in_resp;
  logic [ADDR_WIDTH:0] diff;
  // A borrow makes diff huge, so one compare rejects both below-base and beyond-limit
  always_comb begin
    diff    = {1'b0, s_address_i} - {1'b0, BASE_ADDR};
    req     = s_read_i | s_write_i;
    wr_only = s_write_i & ~s_read_i;
    err     = (diff >= SPAN) | (s_address_i[1:0] != 2'b00) | (s_read_i & s_write_i);
    acc     = state_q == ACCEPT;
    in_resp = state_q == RESP;
    s_waitrequest_o   = ~acc;
    s_readdatavalid_o = in_resp;
    s_readdata_o      = in_resp ? (err_q ? '0 : ram_rdata) : rdata_q;
    s_response_o      = in_resp ? (err_q ? RESP_SLVERR : RESP_OKAY) :
                        (acc & wr_only) ? (err ? RESP_SLVERR : RESP_OKAY) : resp_q;
  end
  corevx_mem_responder_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (acc & wr_only & ~err),
    .re_i    (acc & s_read_i),
    .idx_i   (diff[AW+1:2]),
    .wdata_i (s_writedata_i),
    .be_i    (s_byteenable_i),
    .rdata_o (ram_rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= s_readdata_o;
      resp_q  <= s_response_o;
      case (state_q)
        IDLE: if (req) begin
          state_q <= (WAIT_CYCLES == 0) ? ACCEPT : STALL;
          cnt_q   <= 4'(WAIT_CYCLES);
        end
        STALL: begin
          state_q <= !req ? IDLE : (cnt_q == 4'd1) ? ACCEPT : STALL;
          cnt_q   <= (!req || cnt_q == 4'd1) ? 4'd0 : cnt_q - 4'd1;
        end
        ACCEPT: begin
          err_q   <= err;
          state_q <= !s_read_i ? IDLE : (READ_LATENCY > 1) ? RDWAIT : RESP;
          cnt_q   <= s_read_i ? 4'(READ_LATENCY - 1) : 4'd0;
        end
        RDWAIT: begin
          state_q <= (cnt_q == 4'd1) ? RESP : RDWAIT;
          cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/corevx_mem_responder.md
# corevx_mem_responder

Single-port, word-addressed memory target on the core's memory bus: the responder end of the read/write/waitrequest/readdatavalid/response interface that cache and cache-bypass initiators drive. It inserts a programmable number of wait states, returns read data after a fixed latency, and reports access faults through the 2-bit response code. It serves as on-chip scratch/boot RAM and as the reference target for initiator benches.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DEPTH_WORDS, 1024, number of 32-bit words (power of two)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*4)
- WAIT_CYCLES, 1, extra stall cycles before acceptance (0..15)
- READ_LATENCY, 1, cycles from accept to readdatavalid (1..8)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_address  in  ADDR_WIDTH  byte address
- s_read  in  1  read request, held until accepted
- s_write  in  1  write request, held until accepted
- s_writedata  in  32  write data
- s_byteenable  in  4  per-byte write enables
- s_waitrequest  out  1  high = request not accepted this cycle
- s_readdata  out  32  read data, valid with s_readdatavalid
- s_readdatavalid  out  1  one-cycle read completion strobe
- s_response  out  2  response code: 00 OKAY, 10 SLVERR; valid with s_readdatavalid (reads) or in the write accept cycle

## Operation
- Transfer accepted in a cycle where (s_read|s_write) && !s_waitrequest. One transaction in flight; no pipelining.
- FSM states: IDLE, STALL, ACCEPT, RDWAIT, RESP.
- IDLE: s_waitrequest=1. Request seen -> STALL with counter=WAIT_CYCLES, or ACCEPT directly if WAIT_CYCLES=0.
- STALL: counter decrements each cycle; at 0 -> ACCEPT. Request dropped during STALL -> IDLE, no access.
- ACCEPT: s_waitrequest=0 for exactly one cycle. Write: memory updated at this edge for enabled bytes, s_response driven combinationally this cycle, -> IDLE. Read: memory read at this edge, -> RDWAIT (READ_LATENCY>1) or RESP.
- RDWAIT: counts READ_LATENCY-1 cycles, s_waitrequest=1, -> RESP.
- RESP: s_readdatavalid=1, s_readdata and s_response valid for one cycle -> IDLE.
- Fault: address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) or s_address[1:0]!=0 -> SLVERR; write not performed; read returns s_readdata=0.
- s_read and s_write both high: handled as read, response SLVERR, readdata 0, no write.
- s_byteenable=0 on a legal write: OKAY, memory unchanged.
- Word index = (s_address-BASE_ADDR)>>2, width clog2(DEPTH_WORDS); address compare done at full ADDR_WIDTH, no wrap-around.

## Timing
- Reset values: s_waitrequest=1, s_readdatavalid=0, s_readdata=0, s_response=00, FSM=IDLE, counters=0. Memory contents are not reset.
- Request in cycle 0 -> accept in cycle 1+WAIT_CYCLES -> s_readdatavalid in cycle 1+WAIT_CYCLES+READ_LATENCY.
- Back-to-back requests: the next request is seen in IDLE no earlier than the cycle after ACCEPT (write) or RESP (read).
- Reset asserted mid-transaction: outputs go to reset values immediately (asynchronously); any pending read completion is discarded; a write whose ACCEPT edge occurred has completed.
- s_readdata and s_response hold their last value outside RESP; s_readdatavalid is the only qualifier.

## Structure
- corevx_bus_pkg: response localparams (RESP_OKAY=2'b00, RESP_SLVERR=2'b10) and the FSM state enum type.
- Sub-module corevx_mem_responder_array: DEPTH_WORDS x 32 byte-enabled synchronous RAM, one read or write per cycle, no reset, registered read output.

## Test plan
- WAIT_CYCLES=1, READ_LATENCY=1: write 0xDEADBEEF to 0x10, be=4'hF, then read 0x10 -> write accepted cycle 2 with OKAY; read readdatavalid in cycle 3 of its request, data 0xDEADBEEF, OKAY.
- Byte enables: write 0x11223344 be=4'b0101 over 0xFFFFFFFF at 0x20 -> read returns 0xFF22FF44.
- Faults: read 0x1000 (DEPTH 1024 -> limit 0x1000) and read 0x22 -> SLVERR, data 0; write 0x1000 -> SLVERR, memory at 0x0 unchanged.
- WAIT_CYCLES=3, READ_LATENCY=4: read request cycle 0 -> waitrequest low only in cycle 4, readdatavalid only in cycle 8.
- Read and write both high at 0x30 -> SLVERR on readdatavalid, word 0x30 unchanged; request dropped during STALL -> no accept, returns to IDLE.
- Assert rst_n low during RDWAIT -> readdatavalid never pulses, waitrequest=1 immediately; after release, previously written 0xDEADBEEF at 0x10 still reads back.
